// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } uart_state_t;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 234;

endpackage

// File: rtl/uart_if.sv
// CPU-side and serial-side signals of the UART transceiver.
interface uart_if;

    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;

    modport slave (
        input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );

    modport master (
        output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop input synchronizer, mid-bit sampling and framing-error discard.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic             rx_meta, rx_sync;
    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync) state_d = S_START;
            end
            // Recheck at mid-start so a short low glitch returns to idle silently.
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                    if (rx_sync) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEANUP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, one-cycle done pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
        end
    end

    // Outputs decode the registered state, so reset forces the line high on the next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        o_Tx_Serial = 1'b1;
        o_Tx_Active = 1'b0;
        o_Tx_Done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (i_Tx_DV) begin
                    byte_d  = i_Tx_Byte;
                    state_d = S_START;
                end
            end
            S_START: begin
                o_Tx_Active = 1'b1;
                o_Tx_Serial = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                o_Tx_Active = 1'b1;
                o_Tx_Serial = byte_q[idx_q];
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                o_Tx_Active = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CLEANUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLEANUP: begin
                o_Tx_Done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_transceiver.sv
// Thin wrapper pairing an independent UART transmitter and receiver on one bit period.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic    i_Clock,
    input  logic    i_Reset,
    uart_if.slave   bus
);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Tx_DV     (bus.i_Tx_DV),
        .i_Tx_Byte   (bus.i_Tx_Byte),
        .o_Tx_Active (bus.o_Tx_Active),
        .o_Tx_Serial (bus.o_Tx_Serial),
        .o_Tx_Done   (bus.o_Tx_Done)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (bus.i_Rx_Serial),
        .o_Rx_DV     (bus.o_Rx_DV),
        .o_Rx_Byte   (bus.o_Rx_Byte)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at 8 clocks per bit, including tx->rx loopback.
module tb_uart_transceiver;

    localparam int unsigned CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_en = 1'b0;
    logic rx_drive = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int rx_count = 0;
    logic [7:0] rx_q[$];

    uart_if bus ();

    assign bus.i_Rx_Serial = loop_en ? bus.o_Tx_Serial : rx_drive;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_Rx_DV) begin
            rx_count <= rx_count + 1;
            rx_q.push_back(bus.o_Rx_Byte);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobes b, then follows the 80-cycle frame; optionally strobes inj at cycle inject_at.
    task automatic tx_frame(input logic [7:0] b, input int inject_at, input logic [7:0] inj,
                            input string tag);
        logic [9:0] f;
        int bad, act, dn;
        f = {1'b1, b, 1'b0};
        bad = 0; act = 0; dn = 0;
        @(negedge clk);
        bus.i_Tx_DV = 1'b1;
        bus.i_Tx_Byte = b;
        @(negedge clk);
        bus.i_Tx_DV = 1'b0;
        bus.i_Tx_Byte = ~b;
        for (int i = 0; i < 80; i++) begin
            if (bus.o_Tx_Serial !== f[i / 8]) bad++;
            if (bus.o_Tx_Active === 1'b1) act++;
            if (bus.o_Tx_Done !== 1'b0) dn++;
            if (i == inject_at) begin
                bus.i_Tx_DV = 1'b1;
                bus.i_Tx_Byte = inj;
            end else if (i == inject_at + 1) begin
                bus.i_Tx_DV = 1'b0;
            end
            @(negedge clk);
        end
        check_eq({tag, "_line_errs"}, bad, 0);
        check_eq({tag, "_active_cycles"}, act, 80);
        check_eq({tag, "_early_done"}, dn, 0);
        check_eq({tag, "_done_end"}, {bus.o_Tx_Done, bus.o_Tx_Active, bus.o_Tx_Serial}, 3'b101);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        int base;
        int qb;
        bus.i_Tx_DV = 1'b0;
        bus.i_Tx_Byte = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        check_eq("reset_tx", {bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done}, 3'b100);
        check_eq("reset_rx", {bus.o_Rx_DV, bus.o_Rx_Byte}, 9'h000);

        // 1: TX 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        tx_frame(8'hA5, -1, 8'h00, "tx_a5");
        @(negedge clk);
        check_eq("tx_a5_done_1cyc", bus.o_Tx_Done, 1'b0);

        // 2: RX 0x3C
        base = rx_count;
        rx_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("rx_3c_pulses", rx_count - base, 1);
        check_eq("rx_3c_byte", bus.o_Rx_Byte, 8'h3C);
        repeat (30) @(negedge clk);
        check_eq("rx_3c_held", bus.o_Rx_Byte, 8'h3C);

        // 3: glitch and framing error, then recovery
        base = rx_count;
        rx_drive = 1'b0;
        repeat (2) @(negedge clk);
        rx_drive = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("rx_glitch_pulses", rx_count - base, 0);
        check_eq("rx_glitch_byte", bus.o_Rx_Byte, 8'h3C);
        rx_frame(8'hA7, 1'b0);
        repeat (30) @(negedge clk);
        check_eq("rx_frame_err_pulses", rx_count - base, 0);
        check_eq("rx_frame_err_byte", bus.o_Rx_Byte, 8'h3C);
        rx_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("rx_recover_pulses", rx_count - base, 1);
        check_eq("rx_recover_byte", bus.o_Rx_Byte, 8'h5A);

        // 4: loopback back-to-back
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        base = rx_count;
        qb = rx_q.size();
        tx_frame(8'h00, -1, 8'h00, "lb_00");
        tx_frame(8'hFF, -1, 8'h00, "lb_ff");
        tx_frame(8'h55, -1, 8'h00, "lb_55");
        repeat (30) @(negedge clk);
        check_eq("lb_pulses", rx_count - base, 3);
        check_eq("lb_byte0", (rx_q.size() > qb) ? rx_q[qb] : 8'hEE, 8'h00);
        check_eq("lb_byte1", (rx_q.size() > qb + 1) ? rx_q[qb + 1] : 8'hEE, 8'hFF);
        check_eq("lb_byte2", (rx_q.size() > qb + 2) ? rx_q[qb + 2] : 8'hEE, 8'h55);

        // 5: strobe during an active frame is ignored
        base = rx_count;
        qb = rx_q.size();
        tx_frame(8'h34, 20, 8'h12, "tx_34_inj");
        tx_frame(8'h56, -1, 8'h00, "tx_56");
        repeat (30) @(negedge clk);
        check_eq("inj_pulses", rx_count - base, 2);
        check_eq("inj_byte0", (rx_q.size() > qb) ? rx_q[qb] : 8'hEE, 8'h34);
        check_eq("inj_byte1", (rx_q.size() > qb + 1) ? rx_q[qb + 1] : 8'hEE, 8'h56);

        // 6: reset mid-TX and mid-RX
        loop_en = 1'b0;
        @(negedge clk);
        rx_drive = 1'b0;
        bus.i_Tx_DV = 1'b1;
        bus.i_Tx_Byte = 8'h0F;
        @(negedge clk);
        bus.i_Tx_DV = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("pre_reset_active", bus.o_Tx_Active, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_tx", {bus.o_Tx_Serial, bus.o_Tx_Active, bus.o_Tx_Done}, 3'b100);
        check_eq("mid_reset_rx", {bus.o_Rx_DV, bus.o_Rx_Byte}, 9'h000);
        rx_drive = 1'b1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        base = rx_count;
        tx_frame(8'hC3, -1, 8'h00, "post_reset");
        repeat (30) @(negedge clk);
        check_eq("post_reset_pulses", rx_count - base, 1);
        check_eq("post_reset_byte", bus.o_Rx_Byte, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
